// File: rtl/wb_div_pkg.sv
// Shared definitions for the Wishbone divider initiator: register map,
// status bit position and the sequencing FSM encoding.
package wb_div_pkg;

   localparam logic [7:0] DVD  = 8'h00;
   localparam logic [7:0] DVS  = 8'h04;
   localparam logic [7:0] CTRL = 8'h08;
   localparam logic [7:0] STAT = 8'h0C;
   localparam logic [7:0] QUO  = 8'h10;
   localparam logic [7:0] REM  = 8'h14;

   localparam int STAT_DONE_BIT = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_DVD,
      S_WR_DVS,
      S_WR_CTRL,
      S_RD_STAT,
      S_RD_QUO,
      S_RD_REM,
      S_FIN
   } state_e;

   function automatic logic [7:0] reg_ofs(input state_e s);
      case (s)
         S_WR_DVD:  return DVD;
         S_WR_DVS:  return DVS;
         S_WR_CTRL: return CTRL;
         S_RD_STAT: return STAT;
         S_RD_QUO:  return QUO;
         S_RD_REM:  return REM;
         default:   return 8'h00;
      endcase
   endfunction

   function automatic logic is_xfer(input state_e s);
      return (s != S_IDLE) && (s != S_FIN);
   endfunction

   function automatic logic is_write(input state_e s);
      return (s == S_WR_DVD) || (s == S_WR_DVS) || (s == S_WR_CTRL);
   endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// One Wishbone classic transfer: holds stb until ack or timeout, then forces
// a single idle gap cycle before the next request can launch.
module wb_single_xfer #(
   parameter int WBW            = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             req_i,
   input  logic             we_i,
   input  logic [WBW-1:0]   adr_i,
   input  logic [WBW-1:0]   wdata_i,
   output logic             ok_o,
   output logic             timeout_o,
   output logic [WBW-1:0]   rdata_o,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [WBW/8-1:0] wbm_sel_o,
   output logic [WBW-1:0]   wbm_adr_o,
   output logic [WBW-1:0]   wbm_dat_o,
   input  logic [WBW-1:0]   wbm_dat_i,
   input  logic             wbm_ack_i
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic           cyc_q, cyc_d;
   logic           we_q, we_d;
   logic [WBW-1:0] adr_q, adr_d;
   logic [WBW-1:0] dat_q, dat_d;
   logic [TW-1:0]  tmo_q, tmo_d;

   assign ok_o      = cyc_q & wbm_ack_i;
   assign timeout_o = cyc_q & ~wbm_ack_i & (tmo_q == TW'(TIMEOUT_CYCLES - 1));
   assign rdata_o   = wbm_dat_i;

   // A request is only taken while cyc is low, so the cycle after an ack
   // is always an idle gap even if the caller keeps req_i high.
   always_comb begin
      cyc_d = cyc_q;
      we_d  = we_q;
      adr_d = adr_q;
      dat_d = dat_q;
      tmo_d = tmo_q;
      if (!cyc_q) begin
         if (req_i) begin
            cyc_d = 1'b1;
            we_d  = we_i;
            adr_d = adr_i;
            dat_d = we_i ? wdata_i : '0;
            tmo_d = '0;
         end
      end else if (ok_o || timeout_o) begin
         cyc_d = 1'b0;
         we_d  = 1'b0;
         adr_d = '0;
         dat_d = '0;
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cyc_q <= 1'b0;
         we_q  <= 1'b0;
         adr_q <= '0;
         dat_q <= '0;
         tmo_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         we_q  <= we_d;
         adr_q <= adr_d;
         dat_q <= dat_d;
         tmo_q <= tmo_d;
      end
   end

   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;
   assign wbm_we_o  = we_q;
   assign wbm_sel_o = {(WBW/8){cyc_q}};
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;

endmodule

// File: rtl/wb_div_initiator.sv
// Drives the memory-mapped divider over Wishbone: write operands, go, poll
// status, read quotient and remainder, with timeout and poll-limit aborts.
module wb_div_initiator
   import wb_div_pkg::*;
#(
   parameter int             WBW            = 32,
   parameter int             XLEN           = 32,
   parameter logic [WBW-1:0] BASE_ADR       = 32'h3000_0000,
   parameter int             TIMEOUT_CYCLES = 255,
   parameter int             MAX_POLLS      = 64
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             start_i,
   input  logic [XLEN-1:0]  dividend_i,
   input  logic [XLEN-1:0]  divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [XLEN-1:0]  quotient_o,
   output logic [XLEN-1:0]  remainder_o,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [WBW/8-1:0] wbm_sel_o,
   output logic [WBW-1:0]   wbm_adr_o,
   output logic [WBW-1:0]   wbm_dat_o,
   input  logic [WBW-1:0]   wbm_dat_i,
   input  logic             wbm_ack_i
);

   localparam int PW = $clog2(MAX_POLLS + 1);

   state_e          state_q, state_d;
   logic [XLEN-1:0] dvd_q, dvd_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic            err_q, err_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic [PW-1:0]   poll_q, poll_d;

   logic            x_req, x_we, x_ok, x_tmo;
   logic [WBW-1:0]  x_adr, x_wdata, x_rdata;
   logic            stat_done, last_poll;

   assign stat_done = x_rdata[STAT_DONE_BIT];
   assign last_poll = (poll_q == PW'(MAX_POLLS - 1));

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_i) state_d = S_WR_DVD;
         S_FIN:  state_d = S_IDLE;
         default: begin
            if (x_tmo) begin
               state_d = S_FIN;
            end else if (x_ok) begin
               case (state_q)
                  S_WR_DVD:  state_d = S_WR_DVS;
                  S_WR_DVS:  state_d = S_WR_CTRL;
                  S_WR_CTRL: state_d = S_RD_STAT;
                  S_RD_STAT: begin
                     if (stat_done)      state_d = S_RD_QUO;
                     else if (last_poll) state_d = S_FIN;
                  end
                  S_RD_QUO:  state_d = S_RD_REM;
                  S_RD_REM:  state_d = S_FIN;
                  default:   state_d = state_q;
               endcase
            end
         end
      endcase
   end

   // Requests are derived from the next state so the first write launches on
   // the start edge and each follow-on launches right at the end of the gap.
   always_comb begin
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      err_d   = err_q;
      busy_d  = busy_q;
      poll_d  = poll_q;
      done_d  = 1'b0;

      if (state_q == S_IDLE && start_i) begin
         dvd_d  = dividend_i;
         dvs_d  = divisor_i;
         quo_d  = '0;
         rem_d  = '0;
         err_d  = 1'b0;
         busy_d = 1'b1;
         poll_d = '0;
      end

      if (x_tmo) begin
         err_d = 1'b1;
         quo_d = '0;
         rem_d = '0;
      end else if (x_ok) begin
         case (state_q)
            S_RD_STAT: begin
               if (!stat_done) begin
                  poll_d = poll_q + 1'b1;
                  if (last_poll) err_d = 1'b1;
               end
            end
            S_RD_QUO: quo_d = x_rdata[XLEN-1:0];
            S_RD_REM: rem_d = x_rdata[XLEN-1:0];
            default:  ;
         endcase
      end

      if (state_d == S_FIN && state_q != S_FIN) begin
         done_d = 1'b1;
         busy_d = 1'b0;
      end

      x_req   = is_xfer(state_d);
      x_we    = is_write(state_d);
      x_adr   = BASE_ADR + WBW'(reg_ofs(state_d));
      x_wdata = '0;
      case (state_d)
         S_WR_DVD:  x_wdata = WBW'(dvd_d);
         S_WR_DVS:  x_wdata = WBW'(dvs_d);
         S_WR_CTRL: x_wdata = WBW'(1);
         default:   ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         dvd_q  <= '0;
         dvs_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
         poll_q <= '0;
      end else begin
         dvd_q  <= dvd_d;
         dvs_q  <= dvs_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         err_q  <= err_d;
         done_q <= done_d;
         busy_q <= busy_d;
         poll_q <= poll_d;
      end
   end

   wb_single_xfer #(
      .WBW            (WBW),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_xfer (
      .clk_i     (clk_i),
      .reset_ni  (reset_ni),
      .req_i     (x_req),
      .we_i      (x_we),
      .adr_i     (x_adr),
      .wdata_i   (x_wdata),
      .ok_o      (x_ok),
      .timeout_o (x_tmo),
      .rdata_o   (x_rdata),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_ack_i (wbm_ack_i)
   );

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: tb/tb_wb_div_initiator.sv
// Randomized bench: a behavioural divider responder on the bus, a protocol
// monitor, and per-run expectations derived from operands, delays and polls.
module tb_wb_div_initiator;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic        start_i;
   logic [31:0] dividend_i, divisor_i;
   logic        busy_o, done_o, err_o;
   logic [31:0] quotient_o, remainder_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic [31:0] wbm_dat_i = '0;
   logic        wbm_ack_i = 1'b0;

   always #5 clk_i = ~clk_i;

   wb_div_initiator dut (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .start_i     (start_i),
      .dividend_i  (dividend_i),
      .divisor_i   (divisor_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .quotient_o  (quotient_o),
      .remainder_o (remainder_o),
      .wbm_cyc_o   (wbm_cyc_o),
      .wbm_stb_o   (wbm_stb_o),
      .wbm_we_o    (wbm_we_o),
      .wbm_sel_o   (wbm_sel_o),
      .wbm_adr_o   (wbm_adr_o),
      .wbm_dat_o   (wbm_dat_o),
      .wbm_dat_i   (wbm_dat_i),
      .wbm_ack_i   (wbm_ack_i)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Responder: register-level divider, acks rsp_dly cycles after stb rises.
   int          rsp_dly    = 1;
   int          done_after = 1;
   bit          no_ack_dvs = 1'b0;
   int          wcnt       = 0;
   int          r_polls    = 0;
   logic [31:0] r_dvd = '0, r_dvs = '0, r_quo = '0, r_rem = '0;

   always @(posedge clk_i) begin
      wbm_ack_i <= 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i &&
          !(no_ack_dvs && wbm_adr_o == BASE + 32'h4)) begin
         if (wcnt + 1 >= rsp_dly) begin
            wcnt      <= 0;
            wbm_ack_i <= 1'b1;
            wbm_dat_i <= '0;
            if (wbm_we_o) begin
               case (wbm_adr_o - BASE)
                  32'h00: r_dvd <= wbm_dat_o;
                  32'h04: r_dvs <= wbm_dat_o;
                  32'h08: if (wbm_dat_o[0]) begin
                     r_quo   <= (r_dvs != 0) ? r_dvd / r_dvs : '0;
                     r_rem   <= (r_dvs != 0) ? r_dvd % r_dvs : '0;
                     r_polls <= 0;
                  end
                  default: ;
               endcase
            end else begin
               case (wbm_adr_o - BASE)
                  32'h0C: begin
                     r_polls   <= r_polls + 1;
                     wbm_dat_i <= {31'd0, (r_polls + 1 >= done_after)};
                  end
                  32'h10: wbm_dat_i <= r_quo;
                  32'h14: wbm_dat_i <= r_rem;
                  default: ;
               endcase
            end
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         wcnt <= 0;
      end
   end

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [31:0] dat;
   } tx_t;
   tx_t txq[$];

   int          cyc_cnt = 0;
   int          n_done  = 0;
   logic        p_cyc = 1'b0, p_ack = 1'b0, p_we = 1'b0;
   logic [31:0] p_adr = '0, p_dat = '0;

   always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk_i) begin
      if (done_o) n_done <= n_done + 1;
      if (wbm_cyc_o) begin
         chk("stb_eq_cyc", wbm_stb_o, 1'b1);
         chk("sel_ones", wbm_sel_o, 4'hF);
         if (!wbm_we_o) chk("rd_dat_zero", wbm_dat_o, 0);
         if (p_cyc && !p_ack)
            chk("hold_stable", {wbm_adr_o, wbm_we_o, wbm_dat_o}, {p_adr, p_we, p_dat});
         if (wbm_ack_i)
            txq.push_back('{wbm_adr_o, wbm_we_o, wbm_we_o ? wbm_dat_o : wbm_dat_i});
      end else begin
         chk("idle_bus", {wbm_stb_o, wbm_sel_o, wbm_we_o, wbm_adr_o, wbm_dat_o}, 0);
      end
      if (p_cyc && p_ack) chk("gap", wbm_cyc_o, 1'b0);
      p_cyc <= wbm_cyc_o;
      p_ack <= wbm_ack_i;
      p_adr <= wbm_adr_o;
      p_we  <= wbm_we_o;
      p_dat <= wbm_dat_o;
   end

   int t0 = 0;

   task automatic do_start(input logic [31:0] a, input logic [31:0] b);
      txq.delete();
      @(negedge clk_i);
      chk("done_pulse_len", done_o, 1'b0);
      start_i    = 1'b1;
      dividend_i = a;
      divisor_i  = b;
      @(posedge clk_i);
      #1;
      t0      = cyc_cnt;
      start_i = 1'b0;
      chk("busy_after_start", busy_o, 1'b1);
      chk("clear_on_start", {err_o, quotient_o, remainder_o}, 0);
   endtask

   task automatic wait_done(output int lat);
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 3000) begin
         @(negedge clk_i);
         n++;
         if (done_o) seen = 1'b1;
      end
      lat = cyc_cnt - t0 + 1;
      chk("done_seen", seen, 1'b1);
      if (seen) chk("busy_low_at_done", busy_o, 1'b0);
   endtask

   // Expected bus sequence for a successful run: 3 writes, polls status reads,
   // then quotient and remainder reads; only write data is compared.
   task automatic chk_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int polls, input int exp_lat, input int lat);
      logic [31:0] ofs, wdat;
      logic        we;
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_err"}, err_o, 1'b0);
      chk({tag, "_quo"}, quotient_o, a / b);
      chk({tag, "_rem"}, remainder_o, a % b);
      chk({tag, "_ntx"}, txq.size(), 5 + polls);
      if (txq.size() == 5 + polls) begin
         for (int i = 0; i < 5 + polls; i++) begin
            we   = (i < 3);
            wdat = (i == 0) ? a : (i == 1) ? b : (i == 2) ? 32'd1 : 32'd0;
            ofs  = (i < 3) ? 32'(i * 4) : (i < 3 + polls) ? 32'h0C :
                   (i == 3 + polls) ? 32'h10 : 32'h14;
            chk({tag, "_tx"}, {txq[i].adr, txq[i].we, txq[i].we ? txq[i].dat : 32'd0},
                {BASE + ofs, we, wdat});
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   initial begin
      int          lat, d, p, n, d0, nstat, nquo;
      logic [31:0] a, b;

      reset_ni   = 1'b0;
      start_i    = 1'b0;
      dividend_i = '0;
      divisor_i  = '0;
      repeat (3) @(negedge clk_i);
      chk("rst_ctl", {busy_o, done_o, err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 0);
      chk("rst_res", {quotient_o, remainder_o}, 0);
      chk("rst_bus", {wbm_adr_o, wbm_dat_o}, 0);
      reset_ni = 1'b1;

      // Zero-wait responder, done on first poll.
      rsp_dly = 1; done_after = 1;
      do_start(32'd100, 32'd7);
      wait_done(lat);
      chk_run("z100_7", 32'd100, 32'd7, 1, 18, lat);

      // Slow responder, done on the fifth poll.
      rsp_dly = 3; done_after = 5;
      do_start(32'hFFFF_FFFF, 32'd1);
      wait_done(lat);
      chk_run("slow_max", 32'hFFFF_FFFF, 32'd1, 5, 10 * 5, lat);

      for (int k = 0; k < 4; k++) begin
         d = $urandom_range(1, 4);
         p = $urandom_range(1, 4);
         a = $urandom;
         b = (k[0]) ? 32'($urandom_range(1, 1000)) : ($urandom | 32'd1);
         rsp_dly = d; done_after = p;
         do_start(a, b);
         wait_done(lat);
         chk_run("rand", a, b, p, (5 + p) * (d + 2), lat);
      end

      // Start pulsed mid-poll must not disturb or queue.
      rsp_dly = 1; done_after = 6;
      do_start(32'd50000, 32'd123);
      n = 0;
      while (txq.size() < 4 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      chk("in_rd_stat", txq.size() >= 4, 1'b1);
      start_i = 1'b1; dividend_i = 32'd7; divisor_i = 32'd1;
      @(negedge clk_i);
      start_i = 1'b0;
      wait_done(lat);
      chk_run("busy_start", 32'd50000, 32'd123, 6, 11 * 3, lat);
      repeat (3) @(negedge clk_i);
      chk("no_queue", {busy_o, wbm_cyc_o}, 0);

      // Responder never acks the divisor write.
      rsp_dly = 1; done_after = 1; no_ack_dvs = 1'b1;
      do_start(32'd9, 32'd3);
      wait_done(lat);
      chk("tmo_lat", lat, 3 + 255 + 1);
      chk("tmo_err", err_o, 1'b1);
      chk("tmo_res", {quotient_o, remainder_o}, 0);
      chk("tmo_cyc", wbm_cyc_o, 1'b0);
      chk("tmo_ntx", txq.size(), 1);
      no_ack_dvs = 1'b0;
      do_start(32'd81, 32'd9);
      wait_done(lat);
      chk_run("after_tmo", 32'd81, 32'd9, 1, 18, lat);

      // Status never reports done.
      done_after = 1_000_000;
      do_start(32'd1234, 32'd5);
      wait_done(lat);
      nstat = 0; nquo = 0;
      foreach (txq[i]) begin
         if (txq[i].adr == BASE + 32'h0C) nstat++;
         if (txq[i].adr == BASE + 32'h10) nquo++;
      end
      chk("poll_lat", lat, (3 + 64) * 3);
      chk("poll_err", err_o, 1'b1);
      chk("poll_nstat", nstat, 64);
      chk("poll_noquo", nquo, 0);
      chk("poll_res", {quotient_o, remainder_o}, 0);

      // Asynchronous reset while stb is waiting in the quotient read.
      rsp_dly = 3; done_after = 1;
      do_start(32'd1000, 32'd17);
      n = 0;
      while (!(wbm_cyc_o && wbm_adr_o == BASE + 32'h10 && !wbm_ack_i) && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      chk("in_rd_quo", wbm_adr_o, BASE + 32'h10);
      d0 = n_done;
      #2 reset_ni = 1'b0;
      #1;
      chk("rst_mid_bus", {wbm_cyc_o, wbm_stb_o, busy_o, done_o}, 0);
      chk("rst_mid_res", {quotient_o, remainder_o, err_o}, 0);
      repeat (2) @(negedge clk_i);
      reset_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("rst_no_done", n_done - d0, 0);
      chk("rst_idle", {busy_o, wbm_cyc_o}, 0);
      rsp_dly = 1;
      do_start(32'd20, 32'd3);
      wait_done(lat);
      chk_run("post_rst", 32'd20, 32'd3, 1, 18, lat);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
